// File: rtl/tlc1549_reader.sv
// rtl/tlc1549_reader.sv - TLC1549 10-bit serial ADC frame reader
module tlc1549_reader #(
    parameter int DATA_BITS = 10,
    parameter int CLK_DIV   = 13,
    parameter int CS_SETUP  = 65,
    parameter int CONV_WAIT = 1100
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_data_valid,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_adc_cs_n,
    output logic                 o_adc_sclk,
    input  logic                 i_adc_dout
);

    localparam int BIT_PERIOD = 2 * CLK_DIV;
    localparam int CNT_MAX_A  = (CS_SETUP > BIT_PERIOD) ? CS_SETUP : BIT_PERIOD;
    localparam int CNT_MAX    = (CNT_MAX_A > CONV_WAIT) ? CNT_MAX_A : CONV_WAIT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BIT_W      = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    // SETUP spans the acceptance cycle plus CS_SETUP counted cycles.
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(CS_SETUP);
    localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_LEN    = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_WAIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_CONV
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic                 w_sample;
    logic                 r_din_meta;
    logic                 r_din_sync;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_busy;
    logic                 r_cs_n;
    logic                 r_sclk;

    // State, phase counter and bit counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next-state, counter reload and sample-point decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (i_start) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_SHIFT: begin
                w_sample = (r_cnt == HIGH_LAST);
                if (r_cnt == PERIOD_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_state_nxt = S_CONV;
                w_cnt_nxt   = '0;
            end
            S_CONV: begin
                if (r_cnt == CONV_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous ADC data line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_din_meta <= 1'b0;
            r_din_sync <= 1'b0;
        end else begin
            r_din_meta <= i_adc_dout;
            r_din_sync <= r_din_meta;
        end
    end

    // Capture one bit at the end of each sclk-high phase, MSB first.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shreg <= '0;
        end else if (w_sample) begin
            r_shreg <= {r_shreg[DATA_BITS-2:0], r_din_sync};
        end
    end

    // Registered pin and status outputs, decoded from the upcoming state so they
    // change cleanly on the same edge as the state itself.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            r_cs_n       <= !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
            r_sclk       <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt < HIGH_LEN);
            r_data_valid <= (w_state_nxt == S_HOLD);
            if (w_state_nxt == S_HOLD) begin
                r_data_out <= r_shreg;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_data_valid = r_data_valid;
    assign o_data_out   = r_data_out;
    assign o_adc_cs_n   = r_cs_n;
    assign o_adc_sclk   = r_sclk;

endmodule

// File: tb/tb_tlc1549_reader.sv
// tb/tb_tlc1549_reader.sv - self-checking bench for tlc1549_reader
module tb_tlc1549_reader;

    localparam int DATA_BITS = 10;
    localparam int CLK_DIV   = 4;
    localparam int CS_SETUP  = 6;
    localparam int CONV_WAIT = 20;

    // Frame timeline in cycles after the acceptance edge.
    localparam int FIRST_SCLK = 1 + CS_SETUP;
    localparam int VALID_T    = 1 + CS_SETUP + 2 * CLK_DIV * DATA_BITS;
    localparam int BUSY_END   = VALID_T + 1 + CONV_WAIT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 o_busy;
    logic                 o_data_valid;
    logic [DATA_BITS-1:0] o_data_out;
    logic                 o_adc_cs_n;
    logic                 o_adc_sclk;
    logic                 adc_dout = 1'b0;

    int checks = 0;
    int errors = 0;

    tlc1549_reader #(
        .DATA_BITS(DATA_BITS),
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CONV_WAIT(CONV_WAIT)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_start     (start),
        .o_busy      (o_busy),
        .o_data_valid(o_data_valid),
        .o_data_out  (o_data_out),
        .o_adc_cs_n  (o_adc_cs_n),
        .o_adc_sclk  (o_adc_sclk),
        .i_adc_dout  (adc_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC model: MSB presented at cs_n fall, next bit on every sclk fall.
    logic [DATA_BITS-1:0] adc_word = '0;
    int adc_idx = 0;
    always @(negedge o_adc_cs_n) begin
        adc_idx  = DATA_BITS - 1;
        adc_dout = adc_word[DATA_BITS-1];
    end
    always @(negedge o_adc_sclk) begin
        if (!o_adc_cs_n) begin
            adc_idx = adc_idx - 1;
            adc_dout = (adc_idx >= 0) ? adc_word[adc_idx] : 1'b0;
        end
    end

    int sclk_rises = 0;
    always @(posedge o_adc_sclk) sclk_rises++;
    always @(negedge o_adc_cs_n) sclk_rises = 0;

    // Frame-level reference model: position within a frame decides every output.
    int                   cyc = 0;
    bit                   m_active = 1'b0;
    int                   m_t = 0;
    logic [DATA_BITS-1:0] m_word = '0;
    logic [DATA_BITS-1:0] m_dout = '0;
    int                   accept_cyc = 0;
    int                   prev_accept_cyc = 0;
    int                   accepts = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_dout   = '0;
        end else begin
            cyc++;
            if (m_active) begin
                m_t++;
                if (m_t == VALID_T) m_dout = m_word;
                if (m_t == BUSY_END) m_active = 1'b0;
            end else if (start) begin
                m_active        = 1'b1;
                m_t             = 0;
                m_word          = adc_word;
                prev_accept_cyc = accept_cyc;
                accept_cyc      = cyc;
                accepts++;
            end
        end
    end

    function automatic logic exp_cs_n();
        return !(m_active && m_t < VALID_T);
    endfunction
    function automatic logic exp_sclk();
        return m_active && m_t >= FIRST_SCLK && m_t < VALID_T
               && ((m_t - FIRST_SCLK) % (2 * CLK_DIV)) < CLK_DIV;
    endfunction

    // Per-cycle comparison plus event recording for the directed checks.
    int   strobe_cnt = 0;
    int   valid_cyc = 0;
    int   rises_at_valid = 0;
    int   fall_cyc = 0;
    int   cs_rise_cyc = 0;
    int   last_gap = 0;
    logic prev_busy = 1'b0;
    logic prev_cs_n = 1'b1;
    always @(negedge clk) begin
        chk("busy", o_busy, m_active);
        chk("data_valid", o_data_valid, m_active && m_t == VALID_T);
        chk("data_out", o_data_out, m_dout);
        chk("cs_n", o_adc_cs_n, exp_cs_n());
        chk("sclk", o_adc_sclk, exp_sclk());
        if (o_data_valid) begin
            strobe_cnt++;
            valid_cyc      = cyc;
            rises_at_valid = sclk_rises;
        end
        if (prev_busy && !o_busy) fall_cyc = cyc;
        if (!prev_cs_n && o_adc_cs_n) cs_rise_cyc = cyc;
        if (prev_cs_n && !o_adc_cs_n) last_gap = cyc - cs_rise_cyc;
        prev_busy = o_busy;
        prev_cs_n = o_adc_cs_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int s;
        s = strobe_cnt;
        for (int k = 0; k < 300; k++) begin
            if (strobe_cnt != s) return;
            step();
        end
        chk({name, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            if (!o_busy) return;
            step();
        end
        chk({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_cyc(input int target);
        for (int k = 0; k < 300 && cyc < target; k++) step();
    endtask

    initial begin
        int s0;
        int a0;
        logic [DATA_BITS-1:0] w;

        repeat (3) step();
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_cs_n", o_adc_cs_n, 1'b1);
        chk("rst_sclk", o_adc_sclk, 1'b0);
        chk("rst_data", o_data_out, 10'h000);
        rst_n = 1'b1;
        repeat (2) step();

        // Single frame timing and content.
        adc_word = 10'h2A5;
        pulse_start();
        wait_valid("t1");
        chk("t1_latency", valid_cyc - accept_cyc, 87);
        chk("t1_data", o_data_out, 10'h2A5);
        chk("t1_sclk_rises", rises_at_valid, 10);
        wait_idle("t1");
        chk("t1_busy_fall", fall_cyc - accept_cyc, 108);

        // Back-to-back extremes.
        adc_word = 10'h3FF;
        pulse_start();
        wait_valid("t2a");
        chk("t2_data_3ff", o_data_out, 10'h3FF);
        wait_idle("t2a");
        adc_word = 10'h000;
        pulse_start();
        wait_valid("t2b");
        chk("t2_data_000", o_data_out, 10'h000);
        chk("t2_cs_gap_ge21", (last_gap >= 21) ? 1 : 0, 1);
        wait_idle("t2b");

        // start while busy is ignored.
        adc_word = 10'h155;
        s0 = strobe_cnt;
        a0 = accepts;
        pulse_start();
        wait_cyc(accept_cyc + 4);
        pulse_start();
        wait_cyc(accept_cyc + 49);
        pulse_start();
        wait_idle("t3");
        chk("t3_strobes", strobe_cnt - s0, 1);
        chk("t3_accepts", accepts - a0, 1);
        chk("t3_data", o_data_out, 10'h155);

        // Reset in the middle of bit 4.
        adc_word = 10'h2CC;
        s0 = strobe_cnt;
        pulse_start();
        wait_cyc(accept_cyc + FIRST_SCLK + 8 * 4 + 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_cs_n", o_adc_cs_n, 1'b1);
        chk("t4_sclk", o_adc_sclk, 1'b0);
        chk("t4_busy", o_busy, 1'b0);
        chk("t4_data", o_data_out, 10'h000);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t4_no_strobe", strobe_cnt - s0, 0);
        adc_word = 10'h1B3;
        pulse_start();
        wait_valid("t4");
        chk("t4_after_data", o_data_out, 10'h1B3);
        wait_idle("t4");

        // start held high: back-to-back frames.
        adc_word = 10'h0F0;
        a0 = accepts;
        start = 1'b1;
        for (int k = 0; k < 400 && accepts - a0 < 3; k++) step();
        start = 1'b0;
        chk("t5_accepts", accepts - a0, 3);
        chk("t5_period", accept_cyc - prev_accept_cyc, 109);
        wait_idle("t5");

        // Walking one: bit order and sample alignment.
        for (int i = 0; i < DATA_BITS; i++) begin
            w = 10'h200;
            adc_word = w >> i;
            pulse_start();
            wait_valid("t6");
            chk("t6_walk", o_data_out, adc_word);
            wait_idle("t6");
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
